// File: rtl/bitvec_frame_pkg.sv
// Shared types and ASCII defaults for the bit-vector frame transmitter
// and any companion receive-side decoder.
package bitvec_frame_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BITS = 2'd1,
      TERM = 2'd2
   } frame_state_e;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_STAR = 8'h2A;

endpackage

// File: rtl/bitvec_frame_tx.sv
// Serialises a snapshotted W-bit vector as ASCII '0'/'1' bytes, LSB first, plus a terminator.
// Optional BITVEC_FRAME_TX_CHANGE_ONLY_EN: only transmit when the vector differs from the last one sent.
module bitvec_frame_tx
   import bitvec_frame_pkg::*;
#(
   parameter int         W         = 64,
   parameter logic [7:0] TERM_CHAR = ASCII_STAR,
   parameter logic [7:0] ZERO_CHAR = ASCII_ZERO
) (
   input  logic         clk_48mhz,
   input  logic         reset,
   input  logic [W-1:0] vec_in,
   input  logic         tx_en,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic         frame_done,
   output logic         busy
);

   localparam int              IDX_W    = (W > 1) ? $clog2(W) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);

   localparam logic [1:0] ST_IDLE = 2'(IDLE);
   localparam logic [1:0] ST_BITS = 2'(BITS);
   localparam logic [1:0] ST_TERM = 2'(TERM);

   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;
   logic [W-1:0]     snapshot;
   logic             next_bit;
   logic             xfer;
   logic             start;

   function automatic logic [7:0] bit_char(input logic b);
      return ZERO_CHAR + {7'd0, b};
   endfunction

   assign idx_nxt  = idx + 1'b1;
   // Mask-and-reduce picks the next bit without an index narrower than the shift range.
   assign next_bit = |(snapshot & (W'(1) << idx_nxt));
   assign xfer     = tx_valid & tx_ready;
   assign busy     = (state != ST_IDLE);

`ifdef BITVEC_FRAME_TX_CHANGE_ONLY_EN
   logic [W-1:0] last_sent;
   logic         first_frame;

   assign start = tx_en & (first_frame | (vec_in != last_sent));

   always_ff @(posedge clk_48mhz) begin
      if (!reset) begin
         last_sent   <= '0;
         first_frame <= 1'b1;
      end else if (state == ST_IDLE && start) begin
         last_sent   <= vec_in;
         first_frame <= 1'b0;
      end
   end
`else
   assign start = tx_en;
`endif

   always_ff @(posedge clk_48mhz) begin
      if (!reset) begin
         state      <= ST_IDLE;
         tx_valid   <= 1'b0;
         tx_data    <= '0;
         frame_done <= 1'b0;
         idx        <= '0;
         snapshot   <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  // First byte comes straight from vec_in so it is valid one cycle after start.
                  snapshot <= vec_in;
                  idx      <= '0;
                  tx_data  <= bit_char(vec_in[0]);
                  tx_valid <= 1'b1;
                  state    <= ST_BITS;
               end
            end
            ST_BITS: begin
               if (xfer) begin
                  if (idx == IDX_LAST) begin
                     tx_data <= TERM_CHAR;
                     state   <= ST_TERM;
                  end else begin
                     idx     <= idx_nxt;
                     tx_data <= bit_char(next_bit);
                  end
               end
            end
            ST_TERM: begin
               if (xfer) begin
                  tx_valid   <= 1'b0;
                  frame_done <= 1'b1;
                  state      <= ST_IDLE;
               end
            end
            default: begin
               tx_valid <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bitvec_frame_tx.sv
// Self-checking bench for bitvec_frame_tx (W=8 and W=1 instances); follows BITVEC_FRAME_TX_CHANGE_ONLY_EN if defined.
module tb_bitvec_frame_tx;

   logic clk_48mhz = 1'b0;
   logic reset     = 1'b0;

   logic [7:0] vec8      = '0;
   logic       tx_en8    = 1'b0;
   logic       tx_ready8 = 1'b1;
   logic [7:0] tx_data8;
   logic       tx_valid8, frame_done8, busy8;

   logic [0:0] vec1      = '0;
   logic       tx_en1    = 1'b0;
   logic       tx_ready1 = 1'b1;
   logic [7:0] tx_data1;
   logic       tx_valid1, frame_done1, busy1;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] got8[$];
   logic       hold_pend = 1'b0;
   logic [7:0] hold_data = '0;

`ifdef BITVEC_FRAME_TX_CHANGE_ONLY_EN
   localparam int REPEATS = 1;
`else
   localparam int REPEATS = 4;
`endif

   always #10 clk_48mhz = ~clk_48mhz;

   bitvec_frame_tx #(.W(8)) dut8 (
      .clk_48mhz (clk_48mhz),
      .reset     (reset),
      .vec_in    (vec8),
      .tx_en     (tx_en8),
      .tx_data   (tx_data8),
      .tx_valid  (tx_valid8),
      .tx_ready  (tx_ready8),
      .frame_done(frame_done8),
      .busy      (busy8)
   );

   bitvec_frame_tx #(.W(1)) dut1 (
      .clk_48mhz (clk_48mhz),
      .reset     (reset),
      .vec_in    (vec1),
      .tx_en     (tx_en1),
      .tx_data   (tx_data1),
      .tx_valid  (tx_valid1),
      .tx_ready  (tx_ready1),
      .frame_done(frame_done1),
      .busy      (busy1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: byte i of a frame for vector v of width w.
   function automatic logic [7:0] exp_byte(input logic [255:0] v, input int w, input int i);
      if (i >= w) return 8'h2A;
      return v[i] ? 8'h31 : 8'h30;
   endfunction

   task automatic check_frame(input string tag, input logic [255:0] v, input int w);
      check({tag, "_len"}, 64'(got8.size() >= w + 1), 1);
      for (int i = 0; i <= w; i++)
         if (got8.size() > 0) check({tag, "_byte"}, got8.pop_front(), exp_byte(v, w, i));
   endtask

   task automatic step();
      @(posedge clk_48mhz);
      #1;
      cyc++;
   endtask

   task automatic wait_done8(input string tag, input int limit);
      int n;
      n = 0;
      while (!frame_done8 && n < limit) begin
         step();
         n++;
      end
      check({tag, "_timeout"}, frame_done8, 1);
   endtask

   // Transfer monitor and hold-stable protocol check on the W=8 instance.
   always @(negedge clk_48mhz) begin
      if (hold_pend) begin
         check("hold_valid", tx_valid8, 1);
         check("hold_data", tx_data8, hold_data);
      end
      if (reset && tx_valid8 && tx_ready8) got8.push_back(tx_data8);
      hold_pend <= reset && tx_valid8 && !tx_ready8;
      hold_data <= tx_data8;
   end

   initial begin
      int t0, t1, cnt, n;
      logic [7:0] v, prev;

      repeat (3) step();
      check("rst_valid", tx_valid8, 0);
      check("rst_data", tx_data8, 0);
      check("rst_busy", busy8, 0);
      check("rst_done", frame_done8, 0);
      check("rst_valid_w1", tx_valid1, 0);
      reset = 1'b1;
      step();

      // Single frame, ready always high
      vec8 = 8'hA5; tx_en8 = 1'b1;
      step();
      tx_en8 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         check("t1_valid", tx_valid8, 1);
         check("t1_data", tx_data8, exp_byte(8'hA5, 8, i));
         check("t1_busy", busy8, 1);
         step();
      end
      check("t1_done", frame_done8, 1);
      check("t1_busy_after", busy8, 0);
      check("t1_valid_after", tx_valid8, 0);
      step();
      check("t1_done_pulse", frame_done8, 0);
      check_frame("t1", 8'hA5, 8);

      // Ready toggling every cycle
      tx_en8 = 1'b1; tx_ready8 = 1'b0;
      step();
      tx_en8 = 1'b0;
      cnt = 0; n = 0;
      while (!frame_done8 && n < 100) begin
         if (tx_valid8) cnt++;
         tx_ready8 = ~tx_ready8;
         step();
         n++;
      end
      check("t2_timeout", frame_done8, 1);
      check("t2_valid_cycles", cnt, 17);
      check_frame("t2", 8'hA5, 8);
      tx_ready8 = 1'b1;
      step();

      // vec_in changes mid-frame; next frame picks up the new value
      vec8 = 8'hA5; tx_en8 = 1'b1;
      step();
      t0 = cyc;
      repeat (3) step();
      vec8 = 8'h00;
      wait_done8("t3a", 50);
      step();
      t1 = cyc;
      check("t3_busy2", busy8, 1);
      check("t3_data2", tx_data8, 8'h30);
      check("t3_period", t1 - t0, 10);
      tx_en8 = 1'b0;
      wait_done8("t3b", 50);
      check_frame("t3_first", 8'hA5, 8);
      check_frame("t3_second", 8'h00, 8);
      step();

      // Random vectors, random ready, vec_in scrambled during the frame
      prev = 8'h00;
      for (int f = 0; f < 8; f++) begin
         v = 8'($urandom);
         while (v == prev) v = 8'($urandom);
         vec8 = v; tx_en8 = 1'b1;
         n = 0;
         do begin
            tx_ready8 = ($urandom_range(0, 3) != 0);
            step();
            n++;
         end while (!busy8 && n < 5);
         check("rnd_start", busy8, 1);
         tx_en8 = 1'b0;
         n = 0;
         while (!frame_done8 && n < 300) begin
            vec8 = 8'($urandom);
            tx_ready8 = ($urandom_range(0, 3) != 0);
            step();
            n++;
         end
         check("rnd_timeout", frame_done8, 1);
         check_frame("rnd", v, 8);
         prev = v;
      end
      tx_ready8 = 1'b1;
      step();

      // Reset mid-frame at idx 4
      vec8 = 8'hA5; tx_en8 = 1'b1;
      step();
      tx_en8 = 1'b0;
      repeat (4) step();
      check("t4_data_idx4", tx_data8, exp_byte(8'hA5, 8, 4));
      reset = 1'b0;
      step();
      check("t4_valid", tx_valid8, 0);
      check("t4_busy", busy8, 0);
      check("t4_data", tx_data8, 0);
      reset = 1'b1;
      cnt = 0;
      repeat (20) begin
         step();
         if (tx_valid8) cnt++;
      end
      check("t4_quiet", cnt, 0);
      check("t4_partial", got8.size(), 4);
      got8.delete();

      // tx_en held high: back-to-back, or once per change in change-only builds
      vec8 = 8'h0F; tx_en8 = 1'b1;
      cnt = 0;
      repeat (40) begin
         step();
         if (frame_done8) cnt++;
      end
      check("t5_frames_0f", cnt, REPEATS);
      for (int i = 0; i < REPEATS; i++) check_frame("t5_0f", 8'h0F, 8);
      vec8 = 8'h10;
      cnt = 0;
      repeat (40) begin
         step();
         if (frame_done8) cnt++;
      end
      tx_en8 = 1'b0;
      check("t5_frames_10", cnt, REPEATS);
      for (int i = 0; i < REPEATS; i++) check_frame("t5_10", 8'h10, 8);
      repeat (3) step();
      check("t5_queue_empty", got8.size(), 0);

      // W=1 instance
      vec1 = 1'b1; tx_en1 = 1'b1;
      step();
      check("w1_valid0", tx_valid1, 1);
      check("w1_data0", tx_data1, 8'h31);
      step();
      check("w1_valid1", tx_valid1, 1);
      check("w1_data1", tx_data1, 8'h2A);
      step();
      check("w1_valid_idle", tx_valid1, 0);
      check("w1_done", frame_done1, 1);
      step();
`ifdef BITVEC_FRAME_TX_CHANGE_ONLY_EN
      check("w1_no_repeat", tx_valid1, 0);
`else
      check("w1_repeat_valid", tx_valid1, 1);
      check("w1_repeat_data", tx_data1, 8'h31);
`endif
      tx_en1 = 1'b0;
      repeat (5) step();
      check("w1_drained", busy1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
